// File: rtl/shift_tx.sv
// shift_tx: valid/ready parallel-in, serial-out transmitter that drives a shift_reg receiver.
// Define SHIFT_TX_PARITY_EN to append one even-parity bit, sent with mode HOLD, to each frame.
module shift_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] par_i,
    input  logic             dir_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             ser_o,
    output logic [1:0]       mode_o,
    output logic             done_o,
    output logic             parity_vld_o
);

    localparam int            CW         = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST       = CW'(WIDTH - 1);
    localparam logic [1:0]    MODE_HOLD  = 2'd0;
    localparam logic [1:0]    MODE_LEFT  = 2'd2;
    localparam logic [1:0]    MODE_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
`ifdef SHIFT_TX_PARITY_EN
        , PARITY = 2'd3
`endif
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             dir;
    logic [CW-1:0]    cnt;
`ifdef SHIFT_TX_PARITY_EN
    logic             parity;
`else
    assign parity_vld_o = 1'b0;
`endif

    // The first bit is driven straight from par_i at acceptance, so shreg
    // holds the remaining bits already shifted one place toward the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            dir     <= 1'b0;
            cnt     <= '0;
            ready_o <= 1'b1;
            ser_o   <= 1'b0;
            mode_o  <= MODE_HOLD;
            done_o  <= 1'b0;
`ifdef SHIFT_TX_PARITY_EN
            parity       <= 1'b0;
            parity_vld_o <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    mode_o <= MODE_HOLD;
                    if (valid_i && ready_o) begin
                        shreg   <= dir_i ? (par_i >> 1) : (par_i << 1);
                        dir     <= dir_i;
                        cnt     <= '0;
                        ready_o <= 1'b0;
                        ser_o   <= dir_i ? par_i[0] : par_i[WIDTH-1];
                        mode_o  <= dir_i ? MODE_RIGHT : MODE_LEFT;
`ifdef SHIFT_TX_PARITY_EN
                        parity  <= ^par_i;
`endif
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        mode_o <= MODE_HOLD;
`ifdef SHIFT_TX_PARITY_EN
                        ser_o        <= parity;
                        parity_vld_o <= 1'b1;
                        state        <= PARITY;
`else
                        ser_o  <= 1'b0;
                        done_o <= 1'b1;
                        state  <= DONE;
`endif
                    end else begin
                        cnt   <= cnt + 1'b1;
                        ser_o <= dir ? shreg[0] : shreg[WIDTH-1];
                        shreg <= dir ? (shreg >> 1) : (shreg << 1);
                    end
                end
`ifdef SHIFT_TX_PARITY_EN
                PARITY: begin
                    ser_o        <= 1'b0;
                    parity_vld_o <= 1'b0;
                    mode_o       <= MODE_HOLD;
                    done_o       <= 1'b1;
                    state        <= DONE;
                end
`endif
                DONE: begin
                    done_o  <= 1'b0;
                    ser_o   <= 1'b0;
                    mode_o  <= MODE_HOLD;
                    cnt     <= '0;
                    ready_o <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_tx.sv
// tb_shift_tx: directed self-checking bench for shift_tx (WIDTH=8) with a behavioural shift_reg receiver.
// Parity checks are compiled in when SHIFT_TX_PARITY_EN is defined.
module tb_shift_tx;

    logic       clk;
    logic       rst;
    logic [7:0] par_i;
    logic       dir_i;
    logic       valid_i;
    logic       ready_o;
    logic       ser_o;
    logic [1:0] mode_o;
    logic       done_o;
    logic       parity_vld_o;

    int vectors;
    int miscompares;
    int done_cnt;
    int acc_cnt;
    logic [7:0] rx;

    shift_tx #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .par_i        (par_i),
        .dir_i        (dir_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .ser_o        (ser_o),
        .mode_o       (mode_o),
        .done_o       (done_o),
        .parity_vld_o (parity_vld_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver model: LEFT shifts D in at the LSB, RIGHT shifts D in at the MSB, HOLD keeps P.
    always @(posedge clk) begin
        case (mode_o)
            2'd2:    rx <= {rx[6:0], ser_o};
            2'd3:    rx <= {ser_o, rx[7:1]};
            default: rx <= rx;
        endcase
        if (done_o) done_cnt <= done_cnt + 1;
        if (valid_i && ready_o && !rst) acc_cnt <= acc_cnt + 1;
    end

    task automatic start_frame(input logic [7:0] word, input logic dir);
        @(negedge clk);
        par_i   = word;
        dir_i   = dir;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        par_i   = ~word;
        dir_i   = ~dir;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_i = 1'b1; par_i = 8'h77; dir_i = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (ready_o !== 1'b1 || ser_o !== 1'b0 || mode_o !== 2'd0 || done_o !== 1'b0 || parity_vld_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_during got ready=%b ser=%b mode=%0d done=%b pv=%b expected 1 0 0 0 0",
                     ready_o, ser_o, mode_o, done_o, parity_vld_o);
        end
        rst = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (ready_o !== 1'b1 || ser_o !== 1'b0 || mode_o !== 2'd0 || done_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_after got ready=%b ser=%b mode=%0d done=%b expected 1 0 0 0",
                     ready_o, ser_o, mode_o, done_o);
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] w;
        int base;
        w = 8'hAA;
        base = done_cnt;
        start_frame(w, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vectors++;
            if (ser_o !== w[7-k] || mode_o !== 2'd2 || ready_o !== 1'b0 || done_o !== 1'b0 || parity_vld_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL msb_bit%0d got ser=%b mode=%0d ready=%b done=%b pv=%b expected ser=%b mode=2 ready=0 done=0 pv=0",
                         k, ser_o, mode_o, ready_o, done_o, parity_vld_o, w[7-k]);
            end
        end
`ifdef SHIFT_TX_PARITY_EN
        @(negedge clk);
`endif
        @(negedge clk);
        vectors++;
        if (done_o !== 1'b1 || ser_o !== 1'b0 || mode_o !== 2'd0 || ready_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL msb_done got done=%b ser=%b mode=%0d ready=%b expected 1 0 0 0", done_o, ser_o, mode_o, ready_o);
        end
        vectors++;
        if (rx !== w) begin
            miscompares++;
            $display("[TB] FAIL msb_rx got %h expected %h", rx, w);
        end
        @(negedge clk);
        vectors++;
        if (done_o !== 1'b0 || ready_o !== 1'b1 || done_cnt - base !== 1) begin
            miscompares++;
            $display("[TB] FAIL msb_end got done=%b ready=%b pulses=%0d expected 0 1 1", done_o, ready_o, done_cnt - base);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] w;
        w = 8'hAA;
        start_frame(w, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vectors++;
            if (ser_o !== w[k] || mode_o !== 2'd3 || ready_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL lsb_bit%0d got ser=%b mode=%0d ready=%b expected ser=%b mode=3 ready=0",
                         k, ser_o, mode_o, ready_o, w[k]);
            end
        end
`ifdef SHIFT_TX_PARITY_EN
        @(negedge clk);
`endif
        @(negedge clk);
        vectors++;
        if (done_o !== 1'b1 || mode_o !== 2'd0 || rx !== w) begin
            miscompares++;
            $display("[TB] FAIL lsb_done got done=%b mode=%0d rx=%h expected done=1 mode=0 rx=%h", done_o, mode_o, rx, w);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        int acc_base;
        a = 8'h55;
        b = 8'h0F;
        @(negedge clk);
        acc_base = acc_cnt;
        par_i = a; dir_i = 1'b0; valid_i = 1'b1;
        @(posedge clk);
        #1;
        par_i = b;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vectors++;
            if (ser_o !== a[7-k] || ready_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL b2b_first_bit%0d got ser=%b ready=%b expected ser=%b ready=0", k, ser_o, ready_o, a[7-k]);
            end
        end
`ifdef SHIFT_TX_PARITY_EN
        @(negedge clk);
`endif
        @(negedge clk);
        vectors++;
        if (done_o !== 1'b1 || ready_o !== 1'b0 || rx !== a) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_done got done=%b ready=%b rx=%h expected done=1 ready=0 rx=%h", done_o, ready_o, rx, a);
        end
        @(negedge clk);
        vectors++;
        if (ready_o !== 1'b1 || done_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_ready got ready=%b done=%b expected 1 0", ready_o, done_o);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) valid_i = 1'b0;
            vectors++;
            if (ser_o !== b[7-k] || mode_o !== 2'd2 || ready_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL b2b_second_bit%0d got ser=%b mode=%0d ready=%b expected ser=%b mode=2 ready=0",
                         k, ser_o, mode_o, ready_o, b[7-k]);
            end
        end
`ifdef SHIFT_TX_PARITY_EN
        @(negedge clk);
`endif
        @(negedge clk);
        vectors++;
        if (done_o !== 1'b1 || rx !== b || acc_cnt - acc_base !== 2) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_done got done=%b rx=%h accepts=%0d expected done=1 rx=%h accepts=2",
                     done_o, rx, acc_cnt - acc_base, b);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] w;
        int base;
        base = done_cnt;
        start_frame(8'hF0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (mode_o !== 2'd0 || ready_o !== 1'b1 || ser_o !== 1'b0 || done_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_async got mode=%0d ready=%b ser=%b done=%b expected 0 1 0 0", mode_o, ready_o, ser_o, done_o);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        vectors++;
        if (done_cnt - base !== 0 || ready_o !== 1'b1 || mode_o !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL midreset_quiet got pulses=%0d ready=%b mode=%0d expected 0 1 0", done_cnt - base, ready_o, mode_o);
        end
        w = 8'h3C;
        start_frame(w, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vectors++;
            if (ser_o !== w[7-k] || mode_o !== 2'd2) begin
                miscompares++;
                $display("[TB] FAIL midreset_next_bit%0d got ser=%b mode=%0d expected ser=%b mode=2", k, ser_o, mode_o, w[7-k]);
            end
        end
`ifdef SHIFT_TX_PARITY_EN
        @(negedge clk);
`endif
        @(negedge clk);
        vectors++;
        if (done_o !== 1'b1 || rx !== w) begin
            miscompares++;
            $display("[TB] FAIL midreset_next_done got done=%b rx=%h expected done=1 rx=%h", done_o, rx, w);
        end
        @(negedge clk);
    endtask

`ifdef SHIFT_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] words [2];
        logic       exp_par [2];
        words[0] = 8'h07; exp_par[0] = 1'b1;
        words[1] = 8'h03; exp_par[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_frame(words[i], 1'b0);
            repeat (8) @(negedge clk);
            vectors++;
            if (parity_vld_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL parity_early got pv=%b expected 0", parity_vld_o);
            end
            @(negedge clk);
            vectors++;
            if (ser_o !== exp_par[i] || parity_vld_o !== 1'b1 || mode_o !== 2'd0 || done_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL parity_%h got ser=%b pv=%b mode=%0d done=%b expected ser=%b pv=1 mode=0 done=0",
                         words[i], ser_o, parity_vld_o, mode_o, done_o, exp_par[i]);
            end
            @(negedge clk);
            vectors++;
            if (done_o !== 1'b1 || parity_vld_o !== 1'b0 || rx !== words[i]) begin
                miscompares++;
                $display("[TB] FAIL parity_done_%h got done=%b pv=%b rx=%h expected done=1 pv=0 rx=%h",
                         words[i], done_o, parity_vld_o, rx, words[i]);
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        done_cnt = 0;
        acc_cnt = 0;
        rx = 8'h00;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef SHIFT_TX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/shift_tx.md
# shift_tx

Parallel-in, serial-out transmitter that pairs with the team's `shift_reg` receiver. It accepts a word over a valid/ready handshake and serialises it one bit per clock. For each bit it drives a serial data line and a 2-bit mode code that plugs straight into the receiver's `D` and `mode_i`, so that after the last bit the receiver's parallel output equals the transmitted word. It sits on the sending side of any point-to-point serial link built from `shift_reg`.

## Interface
Parameters:
- `WIDTH`, default 8: word length in bits; legal range is 2 or more.

Ports:
- `clk`, in, 1: the single clock; everything is on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `par_i`, in, WIDTH: word to transmit; sampled only at acceptance.
- `dir_i`, in, 1: shift order, sampled at acceptance.
  - 0 = MSB first, mode code LEFT (2'd2).
  - 1 = LSB first, mode code RIGHT (2'd3).
- `valid_i`, in, 1: a word is offered on `par_i`.
- `ready_o`, out, 1: the block can accept a word.
- `ser_o`, out, 1: serial bit; connects to the receiver's `D`.
- `mode_o`, out, 2: receiver mode; HOLD=2'd0, LEFT=2'd2, RIGHT=2'd3. 2'd1 (LOAD) is never driven.
- `done_o`, out, 1: one-cycle pulse when a frame completes.
- `parity_vld_o`, out, 1: `ser_o` currently carries the parity bit.

## Operation
- **Outputs:** all outputs are registered.
- **Reset values:**
  - `ready_o`=1.
  - `ser_o`=0, `mode_o`=2'd0, `done_o`=0, `parity_vld_o`=0.
  - State is IDLE and the bit counter is 0.
- **IDLE:**
  - `ready_o`=1 and `mode_o`=HOLD.
  - On `valid_i`&&`ready_o` at a rising edge, the block captures `par_i` into a shift register, captures `dir_i`, and goes to SHIFT.
- **SHIFT:** runs for exactly WIDTH cycles.
  - Each cycle, `ser_o` is the next bit: MSB first when dir=0, LSB first when dir=1.
  - `mode_o` is LEFT when dir=0 and RIGHT when dir=1.
  - `ready_o`=0.
  - The counter runs 0..WIDTH-1 and is `$clog2(WIDTH+1)` bits wide. At count WIDTH-1 the state advances to PARITY (if `PARITY_EN`) or DONE.
- **PARITY** (only with `PARITY_EN`): lasts one cycle.
  - `ser_o` = even parity of the captured word (XOR of all bits).
  - `parity_vld_o`=1 and `mode_o`=HOLD.
- **DONE:** lasts one cycle.
  - `done_o`=1, `mode_o`=HOLD, `ser_o`=0.
  - Next state is IDLE, with `ready_o`=1 from the following cycle.
- **Boundary conditions:**
  - `valid_i` while `ready_o`=0 is ignored; it is not queued.
  - Changes to `par_i` or `dir_i` after acceptance have no effect.
  - Asserting `rst` mid-frame aborts the frame immediately. Outputs return to their reset values asynchronously, and no `done_o` pulse is issued.
  - Holding `valid_i` high gives back-to-back frames: the next word is accepted on the first edge with `ready_o`=1.

## Timing
- **Acceptance:** call the accepting rising edge E0.
- **Bit k:** `ser_o`/`mode_o` are valid from E(k) to E(k+1) for k=0..WIDTH-1, so the receiver samples bit k at E(k+1).
- **Without `PARITY_EN`:**
  - `done_o` is high from E(WIDTH) to E(WIDTH+1).
  - `ready_o` goes high after E(WIDTH+1).
  - Minimum frame period is WIDTH+2 cycles.
- **With `PARITY_EN`:**
  - Parity is driven from E(WIDTH) to E(WIDTH+1).
  - `done_o` is high from E(WIDTH+1) to E(WIDTH+2).
  - Minimum frame period is WIDTH+3 cycles.
- **Latency:** there is no combinational path from any input to any output.

## Configuration
- **`SHIFT_TX_PARITY_EN` defined:**
  - The PARITY state is compiled in and each frame gains one even-parity bit.
  - `mode_o`=HOLD during the parity bit, so the receiver's contents are not disturbed.
- **Not defined:**
  - The PARITY state does not exist and `parity_vld_o` is tied to 0.
  - The port list is identical in both builds.

## Test plan
- **Reset:**
  - Stimulus: assert `rst` with `valid_i`=1 and `par_i`=8'h77.
  - Response: `ready_o`=1, `ser_o`=0, `mode_o`=0 and `done_o`=0, both during reset and one cycle after release.
- **MSB first:**
  - Stimulus: `par_i`=8'hAA, `dir_i`=0, one valid handshake.
  - Response: `ser_o` = 1,0,1,0,1,0,1,0 with `mode_o`=2 for 8 cycles.
  - A connected `shift_reg` then shows P=8'hAA.
  - `done_o` pulses once, at E8 (without parity).
- **LSB first:**
  - Stimulus: `par_i`=8'hAA, `dir_i`=1.
  - Response: `ser_o` = 0,1,0,1,0,1,0,1 with `mode_o`=3 for 8 cycles.
  - The receiver shows P=8'hAA.
- **Busy and back-to-back:**
  - Stimulus: accept 8'h55, then hold `valid_i`=1 with `par_i`=8'h0F throughout.
  - Response: 8'h0F is accepted exactly once, at the first edge after `done_o`.
  - The receiver shows 8'h55, then 8'h0F.
- **Reset mid-frame:**
  - Stimulus: assert `rst` after 3 bits of 8'hF0 have been sent.
  - Response: `mode_o`=0 and `ready_o`=1 immediately, and no `done_o` pulse.
  - A following 8'h3C frame transmits correctly.
- **Parity (macro defined):**
  - Stimulus: send 8'h07.
  - Response: the ninth `ser_o` bit is 1, with `parity_vld_o`=1 and `mode_o`=0.
  - Sending 8'h03 gives parity 0.
